// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster driver for a video DAC on the pixel clock.
//   * Free-running h/v counters produce pixel requests (req_x/req_y/req_valid)
//     for an upstream frame-buffer or sprite pipeline.
//   * The pipeline returns colour exactly LATENCY cycles after each request.
//     Sync and active-video flags travel through a matching delay line so they
//     leave the block aligned with that colour.
//   * Packed {R,G,B} colour is expanded to 8-bit DAC channels by replicating
//     each field's bits downwards (all-ones -> 8'hFF, zero -> 8'h00).
//
// Handshake: there is no back-pressure. A request is presented during every
// cycle in which req_valid=1. The source must drive the matching color_in
// exactly LATENCY cycles later. The request issued in cycle t appears on
// red/green/blue/blank/hsync/vsync in cycle t+LATENCY+1.
//
// Optional feature (macro VGA_TEST_PATTERN_EN):
//   When the macro is defined, the port test_en exists. With test_en=1 at the
//   capture stage, color_in is ignored and eight vertical colour bars are
//   shown instead.
//
// Ports
//   clock        in   pixel clock
//   reset        in   synchronous, active-high
//   color_in     in   packed {R,G,B} for the request issued LATENCY cycles ago
//   test_en      in   colour-bar select (VGA_TEST_PATTERN_EN only)
//   req_x/req_y  out  current request coordinates, 0 outside active area
//   req_valid    out  current request lies inside the active area
//   frame_start  out  1-cycle pulse when the request counters are at (0,0)
//   hsync/vsync  out  DAC sync, aligned with colour
//   red/green/blue out 8-bit DAC colour, 0 outside active video
//   blank        out  high during active video (DAC BLANK_N)
//   sync         out  tied low
//   clk          out  copy of clock for the DAC
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_PULSE    = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_PULSE    = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int R_W        = 3,
    parameter int G_W        = 3,
    parameter int B_W        = 2,
    parameter int LATENCY    = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [R_W+G_W+B_W-1:0]   color_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                     test_en,
`endif
    output logic [9:0]               req_x,
    output logic [9:0]               req_y,
    output logic                     req_valid,
    output logic                     frame_start,
    output logic                     hsync,
    output logic                     vsync,
    output logic [7:0]               red,
    output logic [7:0]               green,
    output logic [7:0]               blue,
    output logic                     blank,
    output logic                     sync,
    output logic                     clk
);

    localparam int C_W     = R_W + G_W + B_W;
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    // Sync windows are [BEG, END) in counter units.
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_PULSE);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FRONT + V_PULSE);

    // One delay-line entry: everything that must stay aligned with colour.
    typedef struct packed {
        logic       valid;
        logic       hs;
        logic       vs;
`ifdef VGA_TEST_PATTERN_EN
        logic [9:0] x;
`endif
    } dly_t;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Request stage. Requests are suppressed while reset is held, so the
    // first request (0,0) and its frame_start pulse appear in the first
    // cycle after reset is released.
    // ------------------------------------------------------------------
    logic w_active;
    logic w_hs_raw;
    logic w_vs_raw;

    assign w_active    = ~reset && (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign req_valid   = w_active;
    assign req_x       = w_active ? r_h_cnt : '0;
    assign req_y       = w_active ? r_v_cnt : '0;
    assign frame_start = ~reset && (r_h_cnt == '0) && (r_v_cnt == '0);

    assign w_hs_raw = ((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    assign w_vs_raw = ((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;

    // ------------------------------------------------------------------
    // Alignment delay line, LATENCY entries deep
    // ------------------------------------------------------------------
    dly_t w_dly_in;
    dly_t w_dly_out;

    always_comb begin
        w_dly_in       = '0;
        w_dly_in.valid = w_active;
        w_dly_in.hs    = w_hs_raw;
        w_dly_in.vs    = w_vs_raw;
`ifdef VGA_TEST_PATTERN_EN
        w_dly_in.x     = req_x;
`endif
    end

    generate
        if (LATENCY == 0) begin : g_no_dly
            assign w_dly_out = w_dly_in;
        end else begin : g_dly
            dly_t r_dly [LATENCY];

            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        r_dly[i]    <= '0;
                        r_dly[i].hs <= ~H_SYNC_POL;
                        r_dly[i].vs <= ~V_SYNC_POL;
                    end
                end else begin
                    r_dly[0] <= w_dly_in;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end

            assign w_dly_out = r_dly[LATENCY-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Colour expansion: the field fills the MSBs and is repeated
    // cyclically into the lower bits.
    // ------------------------------------------------------------------
    function automatic logic [7:0] f_expand(input logic [7:0] v, input int w);
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            e[3'(7 - i)] = v[3'(w - 1 - (i % w))];
        end
        return e;
    endfunction

    logic [7:0] w_r_fld;
    logic [7:0] w_g_fld;
    logic [7:0] w_b_fld;
    logic [7:0] w_red_sel;
    logic [7:0] w_green_sel;
    logic [7:0] w_blue_sel;

    assign w_r_fld = 8'(color_in[C_W-1 -: R_W]);
    assign w_g_fld = 8'(color_in[B_W+G_W-1 -: G_W]);
    assign w_b_fld = 8'(color_in[B_W-1:0]);

`ifdef VGA_TEST_PATTERN_EN
    // Bar index comes from the delayed x, so it stays aligned with the
    // other outputs. The last bar absorbs any remainder of H_ACTIVE/8.
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [9:0] w_bar_q;
    logic [2:0] w_bar_idx;
    logic [2:0] w_bar_rgb;

    assign w_bar_q   = w_dly_out.x / 10'(BAR_W);
    assign w_bar_idx = (w_bar_q > 10'd7) ? 3'd7 : w_bar_q[2:0];

    always_comb begin
        w_bar_rgb = 3'b000;
        case (w_bar_idx)
            3'd0:    w_bar_rgb = 3'b111; // white
            3'd1:    w_bar_rgb = 3'b110; // yellow
            3'd2:    w_bar_rgb = 3'b011; // cyan
            3'd3:    w_bar_rgb = 3'b010; // green
            3'd4:    w_bar_rgb = 3'b101; // magenta
            3'd5:    w_bar_rgb = 3'b100; // red
            3'd6:    w_bar_rgb = 3'b001; // blue
            default: w_bar_rgb = 3'b000; // black
        endcase
    end
`endif

    always_comb begin
        w_red_sel   = f_expand(w_r_fld, R_W);
        w_green_sel = f_expand(w_g_fld, G_W);
        w_blue_sel  = f_expand(w_b_fld, B_W);
`ifdef VGA_TEST_PATTERN_EN
        if (test_en) begin
            w_red_sel   = {8{w_bar_rgb[2]}};
            w_green_sel = {8{w_bar_rgb[1]}};
            w_blue_sel  = {8{w_bar_rgb[0]}};
        end
`endif
    end

    // ------------------------------------------------------------------
    // Output capture
    // ------------------------------------------------------------------
    logic       r_hsync;
    logic       r_vsync;
    logic       r_blank;
    logic [7:0] r_red;
    logic [7:0] r_green;
    logic [7:0] r_blue;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hsync <= ~H_SYNC_POL;
            r_vsync <= ~V_SYNC_POL;
            r_blank <= 1'b0;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_hsync <= w_dly_out.hs;
            r_vsync <= w_dly_out.vs;
            r_blank <= w_dly_out.valid;
            r_red   <= w_dly_out.valid ? w_red_sel   : '0;
            r_green <= w_dly_out.valid ? w_green_sel : '0;
            r_blue  <= w_dly_out.valid ? w_blue_sel  : '0;
        end
    end

    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign blank = r_blank;
    assign red   = r_red;
    assign green = r_green;
    assign blue  = r_blue;
    assign sync  = 1'b0;
    assign clk   = clock;

endmodule
